// File: rtl/aligned_write_packer_pkg.sv
// Shared definitions for the aligned write packer: byte/length/pointer widths
// and the packer state encoding.
package aligned_write_packer_pkg;

   localparam int BYTE_BITS               = 8;
   localparam int DEFAULT_WIDTH_BYTES     = 8;
   localparam int DEFAULT_SIZE_BYTES_LOG2 = 15;

   typedef enum logic [0:0] {
      STREAM = 1'b0,
      FLUSH  = 1'b1
   } packer_state_t;

   // Beat length field: 0..WIDTH_BYTES inclusive needs one bit more than the byte offset.
   function automatic int len_bits(input int width_bytes);
      return $clog2(width_bytes) + 1;
   endfunction

   // Committed pointer carries one wrap bit above the history address.
   function automatic int ptr_bits(input int size_log2);
      return size_log2 + 1;
   endfunction

endpackage

// File: rtl/aligned_write_packer_if.sv
// Stream-in / aligned-write-out bundle of the aligned write packer.
interface aligned_write_packer_if
   import aligned_write_packer_pkg::*;
#(
   parameter int WIDTH_BYTES     = DEFAULT_WIDTH_BYTES,
   parameter int SIZE_BYTES_LOG2 = DEFAULT_SIZE_BYTES_LOG2
);
   localparam int LW = len_bits(WIDTH_BYTES);
   localparam int PW = ptr_bits(SIZE_BYTES_LOG2);

   // A beat transfers on a rising edge where in_valid && in_ready; while in_valid
   // is high without in_ready the source holds data/len/last stable.
   logic                         in_valid;
   logic                         in_ready;
   logic [WIDTH_BYTES*8-1:0]     in_data;
   logic [LW-1:0]                in_len;
   logic                         in_last;
   logic                         write_enable;
   logic [SIZE_BYTES_LOG2-1:0]   write_address;
   logic [WIDTH_BYTES*8-1:0]     write_data;
   logic [PW-1:0]                committed_ptr;
   logic                         done;

   modport master (
      output in_valid, in_data, in_len, in_last,
      input  in_ready, write_enable, write_address, write_data, committed_ptr, done
   );

   modport slave (
      input  in_valid, in_data, in_len, in_last,
      output in_ready, write_enable, write_address, write_data, committed_ptr, done
   );

endinterface

// File: rtl/aligned_write_packer_unaligned_byte_merge.sv
// Combinational merge of a beat's low in_len bytes into the accumulator at byte offset cnt.
module aligned_write_packer_unaligned_byte_merge
   import aligned_write_packer_pkg::*;
#(
   parameter int WIDTH_BYTES = DEFAULT_WIDTH_BYTES
) (
   input  logic [2*WIDTH_BYTES*BYTE_BITS-1:0] acc,
   input  logic [$clog2(WIDTH_BYTES)-1:0]     cnt,
   input  logic [WIDTH_BYTES*BYTE_BITS-1:0]   in_data,
   input  logic [len_bits(WIDTH_BYTES)-1:0]   in_len,
   output logic [2*WIDTH_BYTES*BYTE_BITS-1:0] merged,
   output logic [len_bits(WIDTH_BYTES)-1:0]   total
);
   localparam int DW = WIDTH_BYTES*BYTE_BITS;
   localparam int LW = len_bits(WIDTH_BYTES);

   logic [2*DW-1:0] shifted;

   always_comb begin
      shifted = {{DW{1'b0}}, in_data} << (int'(cnt) * BYTE_BITS);
      merged  = acc;
      for (int i = 0; i < 2*WIDTH_BYTES; i++) begin
         if (i >= int'(cnt) && i < int'(cnt) + int'(in_len))
            merged[i*BYTE_BITS +: BYTE_BITS] = shifted[i*BYTE_BITS +: BYTE_BITS];
      end
      total = LW'(cnt) + in_len;
   end

endmodule

// File: rtl/aligned_write_packer.sv
// Packs variable-length byte beats into aligned history-memory word writes and
// publishes a committed byte pointer. PACKER_ZERO_PAD_EN zeroes flush padding bytes.
module aligned_write_packer
   import aligned_write_packer_pkg::*;
#(
   parameter int WIDTH_BYTES     = DEFAULT_WIDTH_BYTES,
   parameter int SIZE_BYTES_LOG2 = DEFAULT_SIZE_BYTES_LOG2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aligned_write_packer_if.slave bus,
   output packer_state_t        dbg_state
);
   localparam int CW = $clog2(WIDTH_BYTES);
   localparam int LW = len_bits(WIDTH_BYTES);
   localparam int PW = ptr_bits(SIZE_BYTES_LOG2);
   localparam int DW = WIDTH_BYTES*BYTE_BITS;
   localparam logic [LW-1:0] FULL_LEN  = LW'(WIDTH_BYTES);
   localparam logic [PW-1:0] WORD_STEP = PW'(WIDTH_BYTES);

   packer_state_t   state;
   logic [2*DW-1:0] acc;
   logic [2*DW-1:0] merged;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   word_ptr;
   logic [LW-1:0]   len_sat;
   logic [LW-1:0]   total;
   logic [LW-1:0]   rem;
   logic            accept;
   logic            active;
   logic            full;
   logic [DW-1:0]   flush_data;

   assign accept    = bus.in_valid && bus.in_ready;
   assign len_sat   = (bus.in_len > FULL_LEN) ? FULL_LEN : bus.in_len;
   assign active    = accept && ((len_sat != '0) || bus.in_last);
   assign full      = (total >= FULL_LEN);
   assign rem       = full ? (total - FULL_LEN) : total;
   assign dbg_state = state;

   aligned_write_packer_unaligned_byte_merge #(.WIDTH_BYTES(WIDTH_BYTES)) u_merge (
      .acc     (acc),
      .cnt     (cnt),
      .in_data (bus.in_data),
      .in_len  (len_sat),
      .merged  (merged),
      .total   (total)
   );

   // In FLUSH, cnt holds the remainder; bytes at or above it are padding.
   always_comb begin
      flush_data = acc[DW-1:0];
`ifdef PACKER_ZERO_PAD_EN
      for (int i = 0; i < WIDTH_BYTES; i++) begin
         if (i >= int'(cnt))
            flush_data[i*BYTE_BITS +: BYTE_BITS] = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= STREAM;
         acc               <= '0;
         cnt               <= '0;
         word_ptr          <= '0;
         bus.in_ready      <= 1'b1;
         bus.write_enable  <= 1'b0;
         bus.write_address <= '0;
         bus.write_data    <= '0;
         bus.committed_ptr <= '0;
         bus.done          <= 1'b0;
      end else begin
         bus.write_enable <= 1'b0;
         bus.done         <= 1'b0;
         case (state)
            STREAM: begin
               if (active) begin
                  if (full) begin
                     bus.write_enable  <= 1'b1;
                     bus.write_address <= word_ptr[SIZE_BYTES_LOG2-1:0];
                     bus.write_data    <= merged[DW-1:0];
                     bus.committed_ptr <= word_ptr + WORD_STEP;
                     word_ptr          <= word_ptr + WORD_STEP;
                     acc               <= {{DW{1'b0}}, merged[2*DW-1:DW]};
                  end else begin
                     // Snaps the pointer up to the word boundary after a flushed stream.
                     bus.committed_ptr <= word_ptr;
                     acc               <= merged;
                  end
                  cnt <= rem[CW-1:0];
                  if (bus.in_last) begin
                     if (rem != '0) begin
                        state        <= FLUSH;
                        bus.in_ready <= 1'b0;
                     end else begin
                        bus.done <= 1'b1;
                     end
                  end
               end
            end
            FLUSH: begin
               bus.write_enable  <= 1'b1;
               bus.write_address <= word_ptr[SIZE_BYTES_LOG2-1:0];
               bus.write_data    <= flush_data;
               bus.committed_ptr <= word_ptr + PW'(cnt);
               bus.done          <= 1'b1;
               word_ptr          <= word_ptr + WORD_STEP;
               cnt               <= '0;
               acc               <= '0;
               state             <= STREAM;
               bus.in_ready      <= 1'b1;
            end
            default: state <= STREAM;
         endcase
      end
   end

endmodule

// File: tb/tb_aligned_write_packer.sv
// Randomised and directed bench for aligned_write_packer with a byte-queue reference model.
module tb_aligned_write_packer;
   import aligned_write_packer_pkg::*;

   localparam int W = 8;
   localparam int S = 15;

   typedef struct {
      int          cyc;
      logic        we;
      logic [14:0] addr;
      logic [63:0] data;
      logic [63:0] mask;
      logic [15:0] ptr;
      logic        dn;
   } ev_t;

   logic          clk;
   logic          rst_n;
   packer_state_t dbg_state;
   int            cyc;
   int            pass_cnt;
   int            total_cnt;

   ev_t           exp_q[$];
   logic [7:0]    byte_q[$];
   int            next_addr;
   int            ptr_model;

   aligned_write_packer_if #(.WIDTH_BYTES(W), .SIZE_BYTES_LOG2(S)) bus ();

   aligned_write_packer #(.WIDTH_BYTES(W), .SIZE_BYTES_LOG2(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic clear_model();
      byte_q.delete();
      exp_q.delete();
      next_addr = 0;
      ptr_model = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: a plain byte FIFO; one full word leaves per beat, the
   // remainder of a last beat leaves as a partial word one cycle later.
   task automatic model_accept(input logic [63:0] data, input int len, input logic last, input int n);
      int   eff;
      int   rem;
      logic was_full;
      ev_t  e;
      eff = (len > W) ? W : len;
      if (eff == 0 && !last) return;
      for (int i = 0; i < eff; i++) byte_q.push_back(data[i*8 +: 8]);
      was_full = (byte_q.size() >= W);
      if (was_full) begin
         e.cyc = n + 1; e.we = 1'b1; e.addr = 15'(next_addr % 32768);
         e.data = '0; e.mask = '1;
         for (int i = 0; i < W; i++) e.data[i*8 +: 8] = byte_q.pop_front();
         e.ptr = 16'((next_addr + W) % 65536);
         e.dn  = last && (byte_q.size() == 0);
         exp_q.push_back(e);
         next_addr = next_addr + W;
      end
      ptr_model = next_addr;
      if (last) begin
         rem = byte_q.size();
         if (rem > 0) begin
            e.cyc = n + 2; e.we = 1'b1; e.addr = 15'(next_addr % 32768);
            e.data = '0; e.mask = '0;
            for (int i = 0; i < rem; i++) begin
               e.data[i*8 +: 8] = byte_q.pop_front();
               e.mask[i*8 +: 8] = 8'hFF;
            end
`ifdef PACKER_ZERO_PAD_EN
            e.mask = '1;
`endif
            e.ptr = 16'((next_addr + rem) % 65536);
            e.dn  = 1'b1;
            exp_q.push_back(e);
            ptr_model = next_addr + rem;
            next_addr = next_addr + W;
         end else if (!was_full) begin
            e.cyc = n + 1; e.we = 1'b0; e.addr = '0; e.data = '0; e.mask = '0;
            e.ptr = 16'(ptr_model % 65536); e.dn = 1'b1;
            exp_q.push_back(e);
         end
      end
   endtask

   // driver
   task automatic send_beat(input logic [63:0] data, input int len, input logic last);
      int wait_cnt;
      @(negedge clk);
      wait_cnt = 0;
      while (!bus.in_ready && wait_cnt < 16) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (!bus.in_ready) begin
         total_cnt++;
         $display("FAIL ready_timeout: in_ready got 0, expected 1");
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_len   = 4'(len);
      bus.in_last  = last;
      model_accept(data, len, last, cyc);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   function automatic logic [63:0] seq_data(input int start);
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(start + i);
      return d;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total_cnt++;
         $display("FAIL drain_timeout: %0d events still pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && (bus.write_enable || bus.done)) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_output: we=%0b done=%0b addr=%0h, expected no output",
                     bus.write_enable, bus.done, bus.write_address);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_cycle", 64'(cyc), 64'(e.cyc));
            check("write_enable", 64'(bus.write_enable), 64'(e.we));
            check("done", 64'(bus.done), 64'(e.dn));
            check("committed_ptr", 64'(bus.committed_ptr), 64'(e.ptr));
            if (e.we) begin
               check("write_address", 64'(bus.write_address), 64'(e.addr));
               check("write_data", bus.write_data & e.mask, e.data & e.mask);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      total_cnt++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      int          len;
      cyc = 0; pass_cnt = 0; total_cnt = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_len = '0; bus.in_last = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_write_enable", 64'(bus.write_enable), 64'd0);
      check("rst_write_address", 64'(bus.write_address), 64'd0);
      check("rst_write_data", bus.write_data, 64'd0);
      check("rst_committed_ptr", 64'(bus.committed_ptr), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      rst_n = 1'b1;

      // eight single-byte beats, then a zero-length last at cnt = 0
      for (int i = 0; i < 8; i++) send_beat(seq_data(i), 1, 1'b0);
      drain();
      check("ptr_after_word", 64'(bus.committed_ptr), 64'd8);
      send_beat($urandom, 0, 1'b1);
      drain();
      check("ptr_after_empty_last", 64'(bus.committed_ptr), 64'd8);

      // 5,5,5,1-last: ends exactly on a word, no flush
      do_reset();
      send_beat(seq_data(0), 5, 1'b0);
      send_beat(seq_data(5), 5, 1'b0);
      send_beat(seq_data(10), 5, 1'b0);
      send_beat(seq_data(15), 1, 1'b1);
      drain();

      // cnt = 3 then len 8 last: full word plus a 3-byte flush
      do_reset();
      send_beat(seq_data(0), 3, 1'b0);
      send_beat(seq_data(3), 8, 1'b1);
      @(negedge clk);
      check("flush_ready_low", 64'(bus.in_ready), 64'd0);
      check("flush_state", 64'(dbg_state), 64'(FLUSH));
      @(negedge clk);
      check("flush_ready_back", 64'(bus.in_ready), 64'd1);
      check("flush_ptr", 64'(bus.committed_ptr), 64'd11);
      send_beat(seq_data(0), 1, 1'b0);
      @(negedge clk);
      check("ptr_snap", 64'(bus.committed_ptr), 64'd16);

      // reset while 5 bytes are pending
      do_reset();
      send_beat(seq_data(0), 8, 1'b0);
      send_beat(seq_data(8), 5, 1'b0);
      drain();
      rst_n = 1'b0;
      #1;
      check("async_rst_ptr", 64'(bus.committed_ptr), 64'd0);
      check("async_rst_we", 64'(bus.write_enable), 64'd0);
      check("async_rst_ready", 64'(bus.in_ready), 64'd1);
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_beat(seq_data(32), 8, 1'b0);
      drain();

      // random beats, including oversize lengths and idle gaps
      do_reset();
      for (int i = 0; i < 400; i++) begin
         len = $urandom_range(0, 9);
         if (len == 9) len = $urandom_range(9, 15);
         d = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send_beat(d, len, ($urandom_range(0, 7) == 0));
      end
      drain();

      // 4097 full words: address and pointer wrap
      do_reset();
      for (int i = 0; i < 4097; i++) send_beat({$urandom, $urandom}, 8, 1'b0);
      drain();
      check("wrap_ptr", 64'(bus.committed_ptr), 64'h8008);
      check("wrap_addr", 64'(bus.write_address), 64'h0000);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
